uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16; FIFO entries, power of 2, minimum 2.
REQ-002 SHALL have parameter PARITY_EN, default 0; 1 stores the receiver parity-error flag with each byte, 0 stores 0.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port rx_busy  input  1  receiver frame-in-progress flag.
REQ-006 SHALL have port rx_dout  input  8  receiver byte, LSB-first assembled, stable while rx_busy low.
REQ-007 SHALL have port rx_parity_err  input  1  receiver parity-error flag for the last frame.
REQ-008 SHALL have port m_ready  input  1  consumer accepts the head entry.
REQ-009 SHALL have port ovf_clr  input  1  clears the sticky overflow flag.
REQ-010 SHALL have port m_valid  output  1  head entry available.
REQ-011 SHALL have port m_data  output  8  head byte.
REQ-012 SHALL have port m_perr  output  1  head parity-error flag.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  occupied entries.
REQ-014 SHALL have ports full, empty  output  1 each  level==DEPTH, level==0.
REQ-015 SHALL have port overflow  output  1  sticky: a byte was dropped.

Function
REQ-016 SHALL register rx_busy into busy_d1 each cycle; frame-done = busy_d1 && !rx_busy.
REQ-017 SHALL push {rx_parity_err & PARITY_EN, rx_dout} on the clock edge ending the frame-done cycle.
REQ-018 SHALL be first-word-fall-through: m_data/m_perr reflect the read-pointer entry; m_valid = !empty.
REQ-019 SHALL pop when m_valid && m_ready; m_data undefined and pop ignored when empty.
REQ-020 SHALL assert m_valid one cycle after frame-done when previously empty (two edges after rx_busy falls).
REQ-021 SHALL use wrap-around read/write pointers of $clog2(DEPTH)+1 bits; full/empty by MSB compare.
REQ-022 SHALL on simultaneous push and pop: accept both, level unchanged, including when full.
REQ-023 SHALL on push when full with no pop: drop the byte, keep contents/pointers, set overflow.
REQ-024 SHALL on push when empty with m_ready high: not bypass; byte pops no earlier than the cycle after the push.
REQ-025 SHALL clear overflow on ovf_clr; a simultaneous overflow event wins (overflow stays 1).
REQ-026 SHALL update level, full, empty registered, consistent with pointers every cycle.

Reset
REQ-027 SHALL, with rstn low at a clock edge, set pointers 0, busy_d1 0, overflow 0; outputs m_valid 0, level 0, empty 1, full 0.
REQ-028 SHALL discard all stored entries on reset mid-operation; no push from a frame-done coinciding with reset.
REQ-029 SHALL not reset the storage array.

Structure
REQ-030 SHALL take UART_DATA_W (8) from the shared uart package; no block-local typedefs.
REQ-031 SHALL instantiate one sub-module uart_sync_fifo (generic width/depth, push/pop, level, full/empty).
REQ-032 SHALL keep frame-done detection and overflow flag in uart_rx_fifo top.

Verification
REQ-033 SHALL cover single frame: rx_busy 1->0 with rx_dout=0xA5, m_ready=0 -> m_valid=1 two edges later, m_data=0xA5, level=1.
REQ-034 SHALL cover fill: 16 frames, no reads, DEPTH=16 -> full=1, level=16; 17th frame 0x3C -> dropped, overflow=1, head unchanged.
REQ-035 SHALL cover full with simultaneous pop: frame 0x77 plus m_ready=1 -> level stays 16, 0x77 is last read out.
REQ-036 SHALL cover parity: PARITY_EN=1, rx_parity_err=1, byte 0x81 -> m_perr=1; PARITY_EN=0 same -> m_perr=0.
REQ-037 SHALL cover overflow clear: ovf_clr=1 with no overflow event -> overflow=0 next cycle; ovf_clr concurrent with overflow -> overflow stays 1.
REQ-038 SHALL cover reset mid-operation: level=5, rstn low one edge -> level=0, empty=1, m_valid=0, overflow=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width and the entry format stored by the RX FIFO.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef struct packed {
        logic                   perr;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock first-word-fall-through FIFO with registered level/full/empty.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      wr_ptr_nxt;
    logic [AW:0]      rd_ptr_nxt;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is accepted only when the head leaves on the same edge.
    always_comb begin
        pop_ok     = pop && !empty;
        push_ok    = push && (!full || pop_ok);
        wr_ptr_nxt = wr_ptr + (AW+1)'(push_ok);
        rd_ptr_nxt = rd_ptr + (AW+1)'(pop_ok);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            level  <= wr_ptr_nxt - rd_ptr_nxt;
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rstn && push_ok) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: captures each completed frame into a FIFO and flags dropped bytes.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rx_busy,
    input  logic [UART_DATA_W-1:0]   rx_dout,
    input  logic                     rx_parity_err,
    input  logic                     m_ready,
    input  logic                     ovf_clr,
    output logic                     m_valid,
    output logic [UART_DATA_W-1:0]   m_data,
    output logic                     m_perr,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    logic      busy_d1;
    logic      frame_done;
    logic      pop;
    logic      ovf_event;
    rx_entry_t push_entry;
    rx_entry_t head_entry;

    always_comb begin
        frame_done      = busy_d1 && !rx_busy;
        pop             = m_valid && m_ready;
        ovf_event       = frame_done && full && !pop;
        push_entry.perr = rx_parity_err & PARITY_EN;
        push_entry.data = rx_dout;
    end

    uart_sync_fifo #(
        .WIDTH ($bits(rx_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (frame_done),
        .wdata (push_entry),
        .pop   (pop),
        .rdata (head_entry),
        .level (level),
        .full  (full),
        .empty (empty)
    );

    // A drop on the same edge as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            busy_d1  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy_d1 <= rx_busy;
            if (ovf_event) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    assign m_valid = !empty;
    assign m_data  = head_entry.data;
    assign m_perr  = head_entry.perr;

endmodule
